mdu_unit: RTL and testbench

- Multi-cycle multiply/divide unit owning the HI/LO registers.
- Acts as responder to the decoder's MduStart/Mduop command stream in the EX stage: executes MULT/MULTU/DIV/DIVU, MTHI/MTLO, MFHI/MFLO.
- Exposes a busy flag that the hazard unit uses to stall any MDU instruction issued while an operation is in flight.

---
 rtl/mdu_pkg.sv | 47 ++++
 rtl/mdu_divider.sv | 102 ++++++++++
 rtl/mdu_unit.sv | 150 +++++++++++++++
 tb/tb_mdu_unit.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mdu_pkg
// Purpose  : Shared types and constants for the multiply/divide unit:
//            the MduOp command encoding, FSM state encodings and the
//            divide-by-zero quotient value.
// Revision : 1.0 - initial release
// ============================================================================
package mdu_pkg;

    // Command encoding carried on the decoder's Mduop field
    typedef enum logic [3:0] {
        MDU_READ_HI            = 4'd0,
        MDU_READ_LO            = 4'd1,
        MDU_WRITE_HI           = 4'd2,
        MDU_WRITE_LO           = 4'd3,
        MDU_START_SIGNED_MUL   = 4'd4,
        MDU_START_UNSIGNED_MUL = 4'd5,
        MDU_START_SIGNED_DIV   = 4'd6,
        MDU_START_UNSIGNED_DIV = 4'd7
    } mdu_op_t;

    // MDU-related subset of the decoder's control bundle
    typedef struct packed {
        logic    mdu_start;
        mdu_op_t mdu_op;
    } mdu_ctrl_t;

    // Top-level sequencing states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } mdu_state_t;

    // Divider core states
    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_FIX  = 2'd2
    } div_state_t;

    // Quotient produced when the divisor is zero (no trap is raised)
    localparam logic [31:0] MDU_DIV_BY_ZERO_LO = 32'hFFFF_FFFF;

endpackage : mdu_pkg
`default_nettype wire

// File: rtl/mdu_divider.sv
`default_nettype none
// ============================================================================
// Module   : mdu_divider
// Purpose  : Iterative radix-2 restoring divider. Works on magnitudes, one
//            quotient bit per cycle, followed by one sign fix-up cycle in
//            which done is high and the corrected results are presented.
// Revision : 1.0 - initial release
// ============================================================================
module mdu_divider
    import mdu_pkg::*;
#(
    parameter int ITERATIONS = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        is_signed,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    localparam int COUNT_W = $clog2(ITERATIONS);

    div_state_t         state;
    div_state_t         next_state;
    logic [COUNT_W-1:0] count;
    logic [31:0]        rem;
    logic [31:0]        quo;
    logic [31:0]        dsr;
    logic               neg_quo;
    logic               neg_rem;
    logic               div_zero;

    logic [32:0]        partial;
    logic [32:0]        diff;
    logic               fits;

    // One restoring step: shift in the next dividend bit and trial-subtract
    always_comb begin
        partial = {rem, quo[31]};
        diff    = partial - {1'b0, dsr};
        fits    = ~diff[32];
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= DIV_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state: run the iterations, then a single fix-up cycle
    always_comb begin
        next_state = state;
        case (state)
            DIV_IDLE: if (start) next_state = DIV_RUN;
            DIV_RUN:  if (count == COUNT_W'(ITERATIONS - 1)) next_state = DIV_FIX;
            DIV_FIX:  next_state = DIV_IDLE;
            default:  next_state = DIV_IDLE;
        endcase
    end

    // Operand latching and the shift/subtract datapath
    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= '0;
            rem      <= '0;
            quo      <= '0;
            dsr      <= '0;
            neg_quo  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
        end else if (state == DIV_IDLE && start) begin
            count    <= '0;
            rem      <= '0;
            // quo starts as the dividend magnitude and is shifted out MSB-first
            quo      <= (is_signed && dividend[31]) ? -dividend : dividend;
            dsr      <= (is_signed && divisor[31])  ? -divisor  : divisor;
            neg_quo  <= is_signed && (dividend[31] ^ divisor[31]);
            neg_rem  <= is_signed && dividend[31];
            div_zero <= (divisor == 32'd0);
        end else if (state == DIV_RUN) begin
            count <= count + COUNT_W'(1);
            rem   <= fits ? diff[31:0] : partial[31:0];
            quo   <= {quo[30:0], fits};
        end
    end

    // Sign fix-up; a zero divisor leaves the dividend in the remainder
    always_comb begin
        done      = (state == DIV_FIX);
        quotient  = div_zero ? MDU_DIV_BY_ZERO_LO : (neg_quo ? -quo : quo);
        remainder = neg_rem ? -rem : rem;
    end

endmodule : mdu_divider
`default_nettype wire

// File: rtl/mdu_unit.sv
`default_nettype none
// ============================================================================
// Module   : mdu_unit
// Purpose  : Multi-cycle multiply/divide unit owning HI/LO. Accepts MduOp
//            commands from EX when idle, raises busy while a multiply or
//            divide is in flight and serves MFHI/MFLO combinationally.
// Revision : 1.0 - initial release
// ============================================================================
module mdu_unit
    import mdu_pkg::*;
#(
    parameter int MUL_CYCLES = 5,
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  operation,
    input  logic [31:0] operand1,
    input  logic [31:0] operand2,
    output logic        busy,
    output logic [31:0] data_read
);

    localparam int MUL_CW = $clog2(MUL_CYCLES + 1);

    mdu_state_t        state;
    mdu_state_t        next_state;
    mdu_op_t           op;
    logic              accept;
    logic              is_mul;
    logic              is_div;
    logic              op_signed;

    logic [31:0]       hi;
    logic [31:0]       lo;
    logic [MUL_CW-1:0] mul_count;
    logic [31:0]       mul_a;
    logic [31:0]       mul_b;
    logic              mul_signed;
    logic [63:0]       mul_a_ext;
    logic [63:0]       mul_b_ext;
    logic [63:0]       product;

    logic              div_done;
    logic [31:0]       div_quotient;
    logic [31:0]       div_remainder;

    // Command decode; start is only honoured while idle
    always_comb begin
        op        = mdu_op_t'(operation);
        busy      = (state != IDLE);
        accept    = start && !busy;
        is_mul    = (op == MDU_START_SIGNED_MUL) || (op == MDU_START_UNSIGNED_MUL);
        is_div    = (op == MDU_START_SIGNED_DIV) || (op == MDU_START_UNSIGNED_DIV);
        op_signed = (op == MDU_START_SIGNED_MUL) || (op == MDU_START_SIGNED_DIV);
    end

    // MFHI/MFLO read port: zero unless an accepted read is present
    always_comb begin
        data_read = 32'd0;
        if (accept) begin
            case (op)
                MDU_READ_HI: data_read = hi;
                MDU_READ_LO: data_read = lo;
                default:     data_read = 32'd0;
            endcase
        end
    end

    // 64-bit product of the latched operands; low 64 bits of the
    // extended multiply are correct for both signed and unsigned
    always_comb begin
        mul_a_ext = mul_signed ? {{32{mul_a[31]}}, mul_a} : {32'd0, mul_a};
        mul_b_ext = mul_signed ? {{32{mul_b[31]}}, mul_b} : {32'd0, mul_b};
        product   = mul_a_ext * mul_b_ext;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state: leave MUL when the delay counter expires, DIV on done
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept && is_mul)      next_state = MUL;
                else if (accept && is_div) next_state = DIV;
            end
            MUL:     if (mul_count == '0) next_state = IDLE;
            DIV:     if (div_done)        next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // HI/LO, multiply operand latches and the multiply delay counter
    always_ff @(posedge clk) begin
        if (reset) begin
            hi         <= 32'd0;
            lo         <= 32'd0;
            mul_count  <= '0;
            mul_a      <= 32'd0;
            mul_b      <= 32'd0;
            mul_signed <= 1'b0;
        end else if (accept) begin
            case (op)
                MDU_WRITE_HI: hi <= operand1;
                MDU_WRITE_LO: lo <= operand1;
                MDU_START_SIGNED_MUL, MDU_START_UNSIGNED_MUL: begin
                    mul_a      <= operand1;
                    mul_b      <= operand2;
                    mul_signed <= op_signed;
                    mul_count  <= MUL_CW'(MUL_CYCLES - 1);
                end
                default: ;
            endcase
        end else if (state == MUL) begin
            if (mul_count == '0) begin
                {hi, lo} <= product;
            end else begin
                mul_count <= mul_count - MUL_CW'(1);
            end
        end else if (state == DIV && div_done) begin
            hi <= div_remainder;
            lo <= div_quotient;
        end
    end

    mdu_divider #(
        .ITERATIONS (DIV_CYCLES)
    ) u_divider (
        .clk       (clk),
        .reset     (reset),
        .start     (accept && is_div),
        .dividend  (operand1),
        .divisor   (operand2),
        .is_signed (op_signed),
        .done      (div_done),
        .quotient  (div_quotient),
        .remainder (div_remainder)
    );

endmodule : mdu_unit
`default_nettype wire

// File: tb/tb_mdu_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdu_unit
// Purpose  : Self-checking bench for mdu_unit. Stimulus pushes expected
//            MFHI/MFLO values into a queue; a monitor pops and compares on
//            every read presented to the unit. HI/LO reference values come
//            from plain 64-bit arithmetic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdu_unit;
    import mdu_pkg::*;

    localparam int MUL_CYCLES = 5;
    localparam int DIV_CYCLES = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  operation;
    logic [31:0] operand1;
    logic [31:0] operand2;
    logic        busy;
    logic [31:0] data_read;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    logic [31:0] exp_q[$];

    mdu_unit #(
        .MUL_CYCLES (MUL_CYCLES),
        .DIV_CYCLES (DIV_CYCLES)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .operation (operation),
        .operand1  (operand1),
        .operand2  (operand2),
        .busy      (busy),
        .data_read (data_read)
    );

    always #5 clk = ~clk;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Monitor: every read presented to the unit is compared with the queue;
    // on all other cycles the read port must be zero
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            if (start && (operation == MDU_READ_HI || operation == MDU_READ_LO)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL read_unexpected: got %08h expected no read", data_read);
                end else begin
                    check32("read", data_read, exp_q.pop_front());
                end
            end else begin
                check32("read_port_idle", data_read, 32'd0);
            end
        end
    end

    // Reference: resulting HI/LO and busy length of a command
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] hi_o, output logic [31:0] lo_o, output int len);
        logic [63:0] p;
        longint      x;
        longint      y;
        longint      q;
        longint      r;
        hi_o = m_hi;
        lo_o = m_lo;
        len  = 0;
        case (op)
            MDU_WRITE_HI: hi_o = a;
            MDU_WRITE_LO: lo_o = a;
            MDU_START_SIGNED_MUL, MDU_START_UNSIGNED_MUL: begin
                if (op == MDU_START_SIGNED_MUL)
                    p = 64'(longint'($signed(a)) * longint'($signed(b)));
                else
                    p = {32'd0, a} * {32'd0, b};
                hi_o = p[63:32];
                lo_o = p[31:0];
                len  = MUL_CYCLES;
            end
            MDU_START_SIGNED_DIV, MDU_START_UNSIGNED_DIV: begin
                len = DIV_CYCLES + 1;
                if (b == 32'd0) begin
                    lo_o = 32'hFFFF_FFFF;
                    hi_o = a;
                end else begin
                    if (op == MDU_START_SIGNED_DIV) begin
                        x = longint'($signed(a));
                        y = longint'($signed(b));
                    end else begin
                        x = longint'({32'd0, a});
                        y = longint'({32'd0, b});
                    end
                    q    = x / y;
                    r    = x % y;
                    lo_o = 32'(q);
                    hi_o = 32'(r);
                end
            end
            default: ;
        endcase
    endtask

    // Drive one command for a single cycle; reads enqueue their expectation
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit ignored);
        start     = 1'b1;
        operation = op;
        operand1  = a;
        operand2  = b;
        if (op == MDU_READ_HI) exp_q.push_back(ignored ? 32'd0 : m_hi);
        if (op == MDU_READ_LO) exp_q.push_back(ignored ? 32'd0 : m_lo);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Count busy cycles with a bound
    task automatic wait_idle(output int n);
        n = 0;
        while (busy !== 1'b0 && n < 200) begin
            n++;
            @(posedge clk);
            #1;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL busy_timeout: got busy=%b after %0d cycles expected 0", busy, n);
        end
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] nh;
        logic [31:0] nl;
        int          len;
        int          n;
        model(op, a, b, nh, nl, len);
        issue(op, a, b, 1'b0);
        wait_idle(n);
        check32("busy_len", 32'(n), 32'(len));
        m_hi = nh;
        m_lo = nl;
    endtask

    task automatic op_and_read(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        run_op(op, a, b);
        run_op(MDU_READ_HI, 32'd0, 32'd0);
        run_op(MDU_READ_LO, 32'd0, 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish before 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] nh;
        logic [31:0] nl;
        int          len;
        int          n;
        logic [3:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;

        reset     = 1'b1;
        start     = 1'b0;
        operation = 4'd0;
        operand1  = 32'd0;
        operand2  = 32'd0;
        m_hi      = 32'd0;
        m_lo      = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check32("reset_busy", {31'd0, busy}, 32'd0);

        // Reset state and MTHI
        run_op(MDU_READ_HI, 32'd0, 32'd0);
        run_op(MDU_READ_LO, 32'd0, 32'd0);
        run_op(MDU_WRITE_HI, 32'h1234_5678, 32'd0);
        run_op(MDU_READ_HI, 32'd0, 32'd0);
        run_op(MDU_READ_LO, 32'd0, 32'd0);
        run_op(MDU_WRITE_LO, 32'hCAFE_F00D, 32'd0);
        run_op(MDU_READ_LO, 32'd0, 32'd0);

        // Directed multiply and divide cases
        op_and_read(MDU_START_SIGNED_MUL,   32'hFFFF_FFFE, 32'd3);
        op_and_read(MDU_START_UNSIGNED_MUL, 32'hFFFF_FFFE, 32'd3);
        op_and_read(MDU_START_SIGNED_DIV,   32'hFFFF_FFF9, 32'd2);
        op_and_read(MDU_START_UNSIGNED_DIV, 32'd100,       32'd7);
        op_and_read(MDU_START_UNSIGNED_DIV, 32'd5,         32'd0);
        op_and_read(MDU_START_SIGNED_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
        op_and_read(MDU_START_SIGNED_DIV,   32'hFFFF_FFF9, 32'd0);

        // Commands pulsed during a divide are ignored
        model(MDU_START_UNSIGNED_DIV, 32'd1000, 32'd7, nh, nl, len);
        issue(MDU_START_UNSIGNED_DIV, 32'd1000, 32'd7, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        issue(MDU_WRITE_LO, 32'h0000_AAAA, 32'd0, 1'b1);
        issue(MDU_READ_LO, 32'd0, 32'd0, 1'b1);
        wait_idle(n);
        check32("busy_len_with_ignored", 32'(n + 5), 32'(len));
        m_hi = nh;
        m_lo = nl;
        run_op(MDU_READ_LO, 32'd0, 32'd0);
        run_op(MDU_READ_HI, 32'd0, 32'd0);

        // Reset in the middle of a divide
        issue(MDU_START_SIGNED_DIV, 32'd123456, 32'd789, 1'b0);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        check32("busy_mid_div", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_hi  = 32'd0;
        m_lo  = 32'd0;
        check32("busy_after_abort", {31'd0, busy}, 32'd0);
        run_op(MDU_READ_HI, 32'd0, 32'd0);
        run_op(MDU_READ_LO, 32'd0, 32'd0);
        op_and_read(MDU_START_SIGNED_MUL, 32'd3, 32'd4);

        // Randomized command stream
        for (int i = 0; i < 40; i++) begin
            rop = 4'($urandom_range(0, 7));
            ra  = $urandom;
            rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 2)) : $urandom;
            if ($urandom_range(0, 1) == 1) rb = rb >> $urandom_range(0, 31);
            if ($urandom_range(0, 3) == 0) rb = -rb;
            op_and_read(rop, ra, rb);
        end

        @(posedge clk);
        #1;
        check32("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_mdu_unit
`default_nettype wire
